// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz timing constants and widths used by the scan unit
// and by the sprite units that consume its coordinates.
package vga_timing_pkg;

  localparam int CLK_DIV   = 4;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HSYNC_START = H_DISPLAY + H_FRONT;
  localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
  localparam int VSYNC_START = V_DISPLAY + V_FRONT;
  localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

  localparam int COLOR_W = 8;
  localparam int COORD_W = 10;

  // Counter width for a divide-by-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_pixel_divider.sv
// Divides the system clock down to the pixel rate: a one-clk p_tick every
// CLK_DIV clocks, plus the combinational advance strobe the counters use.
module vga_pixel_divider
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic advance,
  output logic p_tick
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_r;
  logic          p_tick_r;

  // advance lines up with the edge on which p_tick rises, so the counters
  // and p_tick change together.
  assign advance = (div_cnt_r == DIV_LAST);
  assign p_tick  = p_tick_r;

  // Free-running divide-by-CLK_DIV counter and registered pixel tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_r <= {DW{1'b0}};
      p_tick_r  <= 1'b0;
    end else begin
      if (advance) begin
        div_cnt_r <= {DW{1'b0}};
      end else begin
        div_cnt_r <= div_cnt_r + DW'(1);
      end
      p_tick_r <= advance;
    end
  end

endmodule

// File: rtl/vga_scan_unit.sv
// VGA scan generator: pixel/line counters, sync decode and a one-pixel
// output pipeline keeping sync, video_on and colour aligned for the DAC.
module vga_scan_unit
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] color_in,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               p_tick,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_tick,
  output logic [COLOR_W-1:0] rgb_out
);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] V_ACT_LAST = COORD_W'(V_DISPLAY - 1);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic               advance_s;
  logic [COORD_W-1:0] h_count_r;
  logic [COORD_W-1:0] v_count_r;
  logic               h_last_s;
  logic               v_last_s;
  logic               active_s;
  logic               hsync_raw_s;
  logic               vsync_raw_s;
  logic               video_on_r;
  logic               hsync_r;
  logic               vsync_r;
  logic               frame_tick_r;
  logic [COLOR_W-1:0] rgb_r;

  vga_pixel_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_divider (
    .clk     (clk),
    .reset   (reset),
    .advance (advance_s),
    .p_tick  (p_tick)
  );

  assign h_last_s    = (h_count_r == H_LAST);
  assign v_last_s    = (v_count_r == V_LAST);
  assign active_s    = (h_count_r < H_ACT) && (v_count_r < V_ACT);
  assign hsync_raw_s = !((h_count_r >= HS_START) && (h_count_r <= HS_END));
  assign vsync_raw_s = !((v_count_r >= VS_START) && (v_count_r <= VS_END));

  // Horizontal and vertical scan counters, stepping once per pixel period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_count_r <= {COORD_W{1'b0}};
      v_count_r <= {COORD_W{1'b0}};
    end else if (advance_s) begin
      if (h_last_s) begin
        h_count_r <= {COORD_W{1'b0}};
        if (v_last_s) begin
          v_count_r <= {COORD_W{1'b0}};
        end else begin
          v_count_r <= v_count_r + COORD_W'(1);
        end
      end else begin
        h_count_r <= h_count_r + COORD_W'(1);
      end
    end
  end

  // One-pixel output pipeline; frame_tick fires as the scan enters line V_DISPLAY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      video_on_r   <= 1'b0;
      hsync_r      <= 1'b1;
      vsync_r      <= 1'b1;
      rgb_r        <= {COLOR_W{1'b0}};
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= advance_s && h_last_s && (v_count_r == V_ACT_LAST);
      if (advance_s) begin
        video_on_r <= active_s;
        hsync_r    <= hsync_raw_s;
        vsync_r    <= vsync_raw_s;
        rgb_r      <= active_s ? color_in : {COLOR_W{1'b0}};
      end
    end
  end

  assign x          = h_count_r;
  assign y          = v_count_r;
  assign video_on   = video_on_r;
  assign hsync      = hsync_r;
  assign vsync      = vsync_r;
  assign frame_tick = frame_tick_r;
  assign rgb_out    = rgb_r;

endmodule

// File: tb/tb_vga_scan_unit.sv
// Bench for vga_scan_unit: full-size instance against a cycle model with a
// pixel scoreboard, plus a shrunken-timing instance for frame-level events.
module tb_vga_scan_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       loop_mode = 1'b0;
  logic [7:0] const_col = 8'hE3;

  logic [7:0] color_m, rgb_m;
  logic [9:0] x_m, y_m;
  logic       pt_m, von_m, hs_m, vs_m, ft_m;

  logic [7:0] color_s, rgb_s;
  logic [9:0] x_s, y_s;
  logic       pt_s, von_s, hs_s, vs_s, ft_s;

  assign color_m = loop_mode ? x_m[7:0] : const_col;
  assign color_s = 8'h5A;

  always #5 clk = ~clk;

  vga_scan_unit dut (
    .clk(clk), .reset(reset), .color_in(color_m), .x(x_m), .y(y_m),
    .p_tick(pt_m), .video_on(von_m), .hsync(hs_m), .vsync(vs_m),
    .frame_tick(ft_m), .rgb_out(rgb_m)
  );

  // 16 px x 11 lines, 2 clks per pixel: 352 clks per frame
  vga_scan_unit #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .clk(clk), .reset(reset), .color_in(color_s), .x(x_s), .y(y_s),
    .p_tick(pt_s), .video_on(von_s), .hsync(hs_s), .vsync(vs_s),
    .frame_tick(ft_s), .rgb_out(rgb_s)
  );

  typedef struct packed {
    logic       video;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } pix_t;

  int   n_checks = 0;
  int   n_fail = 0;
  pix_t sb[$];
  pix_t cur;
  int   m_div, m_h, m_v;
  int   count_hs = 0, hs_low = 0, fall_x = -1;
  logic prev_hs = 1'b1;
  int   s_clk, s_nft, s_last, s_vid, s_vsl, s_prev_y;
  logic s_ft_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_models();
    m_div = 0; m_h = 0; m_v = 0;
    cur = '{video: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 8'h00};
    sb.delete();
    s_clk = 0; s_nft = 0; s_last = 0; s_vid = 0; s_vsl = 0; s_prev_y = 0;
    s_ft_prev = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, x_m, 0);          chk({tag, "_y"}, y_m, 0);
    chk({tag, "_ptick"}, pt_m, 0);     chk({tag, "_ftick"}, ft_m, 0);
    chk({tag, "_von"}, von_m, 0);      chk({tag, "_hs"}, hs_m, 1);
    chk({tag, "_vs"}, vs_m, 1);        chk({tag, "_rgb"}, rgb_m, 0);
    chk({tag, "_s_x"}, x_s, 0);        chk({tag, "_s_y"}, y_s, 0);
    chk({tag, "_s_ptick"}, pt_s, 0);   chk({tag, "_s_ftick"}, ft_s, 0);
    chk({tag, "_s_hs"}, hs_s, 1);      chk({tag, "_s_vs"}, vs_s, 1);
    chk({tag, "_s_rgb"}, rgb_s, 0);
  endtask

  // One clock: advance both models by one edge and compare at the negedge.
  task automatic clk_step();
    bit   adv, efr;
    pix_t e;
    @(negedge clk);
    adv = (m_div == 3);
    m_div = adv ? 0 : m_div + 1;
    efr = 1'b0;
    if (adv) begin
      e.video = (m_h < 640) && (m_v < 480);
      e.hs    = !(m_h >= 656 && m_h <= 751);
      e.vs    = !(m_v >= 490 && m_v <= 491);
      e.rgb   = e.video ? (loop_mode ? m_h[7:0] : const_col) : 8'h00;
      sb.push_back(e);
      efr = (m_h == 799) && (m_v == 479);
      if (m_h == 799) begin
        m_h = 0;
        m_v = (m_v == 524) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
      chk("sb_nonempty", sb.size(), 1);
      if (sb.size() > 0) cur = sb.pop_front();
    end
    chk("ptick", pt_m, adv);
    chk("ftick", ft_m, efr);
    chk("x", x_m, m_h);
    chk("y", y_m, m_v);
    chk("video_on", von_m, cur.video);
    chk("hsync", hs_m, cur.hs);
    chk("vsync", vs_m, cur.vs);
    chk("rgb", rgb_m, cur.rgb);
    if (count_hs != 0 && adv) begin
      if (!hs_m) hs_low++;
      if (prev_hs && !hs_m && fall_x < 0) fall_x = m_h;
      prev_hs = hs_m;
    end

    s_clk++;
    chk("s_ptick", pt_s, (s_clk % 2) == 0);
    chk("s_rgb", rgb_s, von_s ? 8'h5A : 8'h00);
    if (pt_s) begin
      if (von_s) s_vid++;
      if (!vs_s) s_vsl++;
    end
    if (ft_s) begin
      chk("s_ft_width", s_ft_prev, 0);
      chk("s_ft_y", y_s, 6);
      chk("s_ft_prev_y", s_prev_y, 5);
      if (s_nft > 0) begin
        chk("s_ft_period", s_clk - s_last, 352);
        chk("s_vsync_low", s_vsl, 32);
        chk("s_video_px", s_vid, 48);
      end
      s_nft++;
      s_last = s_clk;
      s_vid = 0;
      s_vsl = 0;
    end
    s_ft_prev = ft_s;
    s_prev_y = y_s;
  endtask

  initial begin
    int n_pt;
    reset_models();
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b1;

    n_pt = 0;
    for (int i = 0; i < 12; i++) begin
      clk_step();
      if (pt_m) n_pt++;
    end
    chk("ptick_count_12", n_pt, 3);
    chk("x_after_12", x_m, 3);

    // first line with constant colour, measuring the hsync pulse
    count_hs = 1;
    for (int i = 0; i < 5000 && !(m_v == 1 && m_h == 100); i++) clk_step();
    chk("reach_line1", (m_v == 1 && m_h == 100), 1);
    count_hs = 0;
    chk("hsync_low_px", hs_low, 96);
    chk("hsync_fall_x", fall_x, 657);

    loop_mode = 1'b1;
    for (int i = 0; i < 5000 && !(m_v == 1 && m_h == 700); i++) clk_step();
    chk("reach_loop_end", (m_v == 1 && m_h == 700), 1);
    for (int i = 0; i < 5000 && !(m_v == 2 && m_h == 300); i++) clk_step();
    chk("reach_mid_reset", (m_v == 2 && m_h == 300), 1);

    // asynchronous reset mid-line
    reset = 1'b0;
    #1;
    chk_reset("async");
    repeat (3) @(negedge clk);
    chk_reset("held");
    reset_models();
    reset = 1'b1;
    for (int i = 0; i < 2000; i++) clk_step();
    chk("s_frames_seen", s_nft >= 4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_unit.md
Name: vga_scan_unit

Overview:
Generates 640x480@60Hz VGA timing from the 100 MHz system clock. Drives the scan coordinates (x, y) that every sprite/graphics unit consumes. Captures the combined 8-bit colour those units return and emits it, aligned with hsync/vsync/video_on, to the DAC pins. Also issues a once-per-frame tick at the start of vertical blanking, which game logic uses to update ship/monster positions.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz)
H_DISPLAY, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, active lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
color_in  in  8  combined sprite colour for the current (x, y); combinational from the graphics units
x  out  10  current horizontal scan coordinate (h_count)
y  out  10  current vertical scan coordinate (v_count)
p_tick  out  1  one-clk pulse per pixel period
video_on  out  1  high when the emitted pixel is inside the active area (delayed, aligned with rgb_out)
hsync  out  1  horizontal sync, active low (delayed, aligned)
vsync  out  1  vertical sync, active low (delayed, aligned)
frame_tick  out  1  one-clk pulse at the start of vertical blanking
rgb_out  out  8  pixel colour to the DAC; zero outside the active area

Behaviour:
- Reset (reset=0, asynchronous): div_cnt=0, h_count=0, v_count=0, x=0, y=0, p_tick=0, frame_tick=0, video_on=0, hsync=1, vsync=1, rgb_out=0.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. p_tick is registered and is high for the one clk in which div_cnt==CLK_DIV-1. It is therefore high every 4th clk; the first pulse comes on the 4th clk edge after reset release.
- H_TOTAL=800, V_TOTAL=525, both derived from the parameters.
- Horizontal counter, on p_tick: h_count increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: v_count increments on the p_tick where h_count wraps; at V_TOTAL-1 it wraps to 0. At h=799, v=524 both wrap on the same p_tick.
- No counter changes between p_ticks.
- x=h_count and y=v_count; both are registered counter outputs.
- Raw, undelayed signals, computed from the counters:
  - hsync_raw = low while h_count is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. [656,751].
  - vsync_raw = low while v_count is in [490,491].
  - active = (h_count<640) && (v_count<480).
- Pipeline stage, updated only on p_tick (exactly 1 pixel period of latency):
  - rgb_out <= active ? color_in : 0
  - video_on <= active
  - hsync <= hsync_raw
  - vsync <= vsync_raw
  - Sync and colour therefore stay mutually aligned, one pixel behind x/y.
- frame_tick: registered; high for exactly one clk, on the p_tick at which the counters move to h=0, v=480. Exactly one pulse per 420000 pixel periods.
- Reset asserted mid-frame: every register returns immediately to its reset value. After release, scanning restarts at (0,0) with no partial pulses.
- Widths:
  - h_count and v_count are 10 bits; maximum values 799 and 524.
  - Comparisons are unsigned.
  - div_cnt is $clog2(CLK_DIV) bits, minimum 1.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the timing localparams: H_DISPLAY..V_BACK, H_TOTAL, V_TOTAL, HSYNC_START/END, VSYNC_START/END;
  - COLOR_W=8 and COORD_W=10, reused by ship_unit and the other sprite units.
- One natural sub-module: vga_pixel_divider (parameter CLK_DIV; outputs p_tick). All other logic stays inline.

Test Plan:
- Reset release, then 12 clks -> p_tick high at clks 4, 8, 12 only; x increments 0->1->2->3 on those clks; hsync=vsync=1; rgb_out=0.
- Run one line -> x reaches 799 then returns to 0; y goes 0->1 on that p_tick. hsync is low for exactly 96 p_ticks, falling one pixel after x=656 first appears.
- Full frame (420000 p_ticks) -> frame_tick pulses once, one clk wide, coinciding with y changing 479->480. vsync is low for exactly 1600 p_ticks. The next frame_tick comes exactly 1680000 clks later.
- Drive color_in=8'hE3 constant -> rgb_out=8'hE3 with video_on=1 at output pixels 0..639 of lines 0..479; rgb_out=0 for outputs corresponding to x>=640 or y>=480.
- Colour alignment: color_in = x[7:0] (loopback) -> on each p_tick inside the active area, rgb_out equals the previous x[7:0], i.e. 1-pixel latency.
- Assert reset at (x=300, y=200) for 3 clks -> all outputs return to their reset values within the same clk (asynchronous). After release, x=0, y=0 and scanning resumes normally.
